agc_8363_ctrl: RTL and testbench

- Power-up/on-demand serial configuration sequencer for a dual-channel AGC/VGA front end.
- On a start request it writes:
  - an 8-bit gain word to channel A over a 3-wire bus (CSA/CLKA/DATA);
  - an 8-bit gain word to channel B over a second 3-wire bus (CSB/CLKB/DATB);
  - a 16-bit configuration word to the SPI device (A4 chip select, B4_sclk, B5_spi_sdio).
- Sits between the board-level start strobe and the AGC chip pins; write-only, no readback.

---
 rtl/agc_8363_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_agc_8363_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_8363_ctrl.sv
// Start-triggered serial configuration sequencer for a dual-channel AGC/VGA front end.
// Optional macro AGC_GAIN_STEP_EN: while in DONE, present GS_CODE on the channel B CS/FA pins.
module agc_8363_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [7:0]  GAIN_A   = 8'h20,
  parameter logic [7:0]  GAIN_B   = 8'h20,
  parameter logic [15:0] SPI_WORD = 16'h0000,
  parameter logic [1:0]  GS_CODE  = 2'b00
) (
  input  logic main_clk,
  input  logic rst_n,
  input  logic start,
  output logic A4,
  output logic A5,
  output logic A3_csa,
  output logic A2_faa,
  output logic A1_clka,
  output logic A0_data,
  output logic B4_sclk,
  output logic B3_csb_gs1,
  output logic B2_fab_gs0,
  output logic B1_clkb,
  output logic B0_datb,
  output logic B5_spi_sdio
);

`ifdef AGC_GAIN_STEP_EN
  localparam bit GS_EN = 1'b1;
`else
  localparam bit GS_EN = 1'b0;
`endif

  localparam int unsigned DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_END  = DW'(2 * CLK_DIV - 1);
  // The R/W bit is always driven as write; the device is never read back.
  localparam logic [15:0] SPI_FRAME = {1'b0, SPI_WORD[14:0]};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME_A,
    ST_GAP1,
    ST_FRAME_B,
    ST_GAP2,
    ST_FRAME_SPI,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic cs_spi;
    logic done;
    logic cs_a;
    logic fa_a;
    logic clk_a;
    logic dat_a;
    logic sclk;
    logic cs_b;
    logic fa_b;
    logic clk_b;
    logic dat_b;
    logic sdio;
  } pins_t;

  localparam pins_t PINS_IDLE = '{cs_spi: 1'b1, done: 1'b0, cs_a: 1'b1, fa_a: 1'b0,
                                  clk_a: 1'b0, dat_a: 1'b0, sclk: 1'b0, cs_b: 1'b1,
                                  fa_b: 1'b0, clk_b: 1'b0, dat_b: 1'b0, sdio: 1'b0};

  state_t        state_q, state_nxt;
  logic [DW-1:0] div_q, div_nxt;
  logic [3:0]    bit_q, bit_nxt;
  logic          high_q, high_nxt;
  logic          tail_q, tail_nxt;
  logic          start_d;
  logic          start_edge;
  pins_t         pins_q, pins_nxt;

  always_ff @(posedge main_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      high_q  <= 1'b0;
      tail_q  <= 1'b0;
      start_d <= 1'b0;
      pins_q  <= PINS_IDLE;
    end else begin
      state_q <= state_nxt;
      div_q   <= div_nxt;
      bit_q   <= bit_nxt;
      high_q  <= high_nxt;
      tail_q  <= tail_nxt;
      start_d <= start;
      pins_q  <= pins_nxt;
    end
  end

  // Pins are registered from the next-state view so every pin changes cleanly on one edge.
  always_comb begin
    state_nxt  = state_q;
    div_nxt    = div_q;
    bit_nxt    = bit_q;
    high_nxt   = high_q;
    tail_nxt   = tail_q;
    pins_nxt   = PINS_IDLE;
    start_edge = start & ~start_d;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_nxt = ST_FRAME_A;
          div_nxt   = '0;
          bit_nxt   = 4'd7;
          high_nxt  = 1'b0;
          tail_nxt  = 1'b0;
        end
      end
      ST_GAP1, ST_GAP2: begin
        if (div_q == GAP_END) begin
          state_nxt = (state_q == ST_GAP1) ? ST_FRAME_B : ST_FRAME_SPI;
          bit_nxt   = (state_q == ST_GAP1) ? 4'd7 : 4'd15;
          div_nxt   = '0;
          high_nxt  = 1'b0;
          tail_nxt  = 1'b0;
        end else begin
          div_nxt = div_q + DW'(1);
        end
      end
      default: begin
        if (div_q != HALF_END) begin
          div_nxt = div_q + DW'(1);
        end else begin
          div_nxt = '0;
          if (tail_q) begin
            tail_nxt = 1'b0;
            high_nxt = 1'b0;
            case (state_q)
              ST_FRAME_A: state_nxt = ST_GAP1;
              ST_FRAME_B: state_nxt = ST_GAP2;
              default:    state_nxt = ST_DONE;
            endcase
          end else if (!high_q) begin
            high_nxt = 1'b1;
          end else begin
            high_nxt = 1'b0;
            if (bit_q == 4'd0) begin
              tail_nxt = 1'b1;
            end else begin
              bit_nxt = bit_q - 4'd1;
            end
          end
        end
      end
    endcase

    pins_nxt.done = (state_nxt == ST_DONE);
    case (state_nxt)
      ST_FRAME_A: begin
        pins_nxt.cs_a  = 1'b0;
        pins_nxt.clk_a = high_nxt;
        pins_nxt.dat_a = GAIN_A[bit_nxt[2:0]];
      end
      ST_FRAME_B: begin
        pins_nxt.cs_b  = 1'b0;
        pins_nxt.clk_b = high_nxt;
        pins_nxt.dat_b = GAIN_B[bit_nxt[2:0]];
      end
      ST_FRAME_SPI: begin
        pins_nxt.cs_spi = 1'b0;
        pins_nxt.sclk   = high_nxt;
        pins_nxt.sdio   = SPI_FRAME[bit_nxt];
      end
      ST_DONE: begin
        if (GS_EN) begin
          pins_nxt.cs_b = GS_CODE[1];
          pins_nxt.fa_b = GS_CODE[0];
        end
      end
      default: ;
    endcase
  end

  assign A4          = pins_q.cs_spi;
  assign A5          = pins_q.done;
  assign A3_csa      = pins_q.cs_a;
  assign A2_faa      = pins_q.fa_a;
  assign A1_clka     = pins_q.clk_a;
  assign A0_data     = pins_q.dat_a;
  assign B4_sclk     = pins_q.sclk;
  assign B3_csb_gs1  = pins_q.cs_b;
  assign B2_fab_gs0  = pins_q.fa_b;
  assign B1_clkb     = pins_q.clk_b;
  assign B0_datb     = pins_q.dat_b;
  assign B5_spi_sdio = pins_q.sdio;

endmodule

// File: tb/tb_agc_8363_ctrl.sv
// Self-checking bench for agc_8363_ctrl: a timeline model of the whole sequence is compared
// against the pins every cycle, plus literal frame-level checks (CS width and shifted-in words).
module tb_agc_8363_ctrl;

  localparam int          D        = 4;
  localparam logic [7:0]  GAIN_A   = 8'hA5;
  localparam logic [7:0]  GAIN_B   = 8'h3C;
  localparam logic [15:0] SPI_WORD = 16'h0A81;
  localparam logic [1:0]  GS_CODE  = 2'b01;

`ifdef AGC_GAIN_STEP_EN
  localparam bit GS_ON = 1'b1;
  localparam logic [11:0] PINS_DONE = 12'b1110_0000_1000;
`else
  localparam bit GS_ON = 1'b0;
  localparam logic [11:0] PINS_DONE = 12'b1110_0001_0000;
`endif
  localparam logic [11:0] PINS_IDLE = 12'b1010_0001_0000;

  // Sequence timeline in cycles from the clock that accepts the start edge.
  localparam int LA        = (2 * 8 + 1) * D;
  localparam int G         = 2 * D;
  localparam int LB        = (2 * 8 + 1) * D;
  localparam int LS        = (2 * 16 + 1) * D;
  localparam int SPI_START = LA + G + LB + G;
  localparam int TOTAL     = SPI_START + LS;

  logic main_clk = 1'b0;
  logic rst_n    = 1'b0;
  logic start    = 1'b0;
  logic A4, A5, A3_csa, A2_faa, A1_clka, A0_data;
  logic B4_sclk, B3_csb_gs1, B2_fab_gs0, B1_clkb, B0_datb, B5_spi_sdio;
  logic [11:0] dut_pins;

  int total = 0;
  int bad   = 0;

  agc_8363_ctrl #(
    .CLK_DIV (D),
    .GAIN_A  (GAIN_A),
    .GAIN_B  (GAIN_B),
    .SPI_WORD(SPI_WORD),
    .GS_CODE (GS_CODE)
  ) dut (
    .main_clk   (main_clk),
    .rst_n      (rst_n),
    .start      (start),
    .A4         (A4),
    .A5         (A5),
    .A3_csa     (A3_csa),
    .A2_faa     (A2_faa),
    .A1_clka    (A1_clka),
    .A0_data    (A0_data),
    .B4_sclk    (B4_sclk),
    .B3_csb_gs1 (B3_csb_gs1),
    .B2_fab_gs0 (B2_fab_gs0),
    .B1_clkb    (B1_clkb),
    .B0_datb    (B0_datb),
    .B5_spi_sdio(B5_spi_sdio)
  );

  always #5 main_clk = ~main_clk;

  assign dut_pins = {A4, A5, A3_csa, A2_faa, A1_clka, A0_data,
                     B4_sclk, B3_csb_gs1, B2_fab_gs0, B1_clkb, B0_datb, B5_spi_sdio};

  // Returns {serial clock, serial data} at offset off into a W-bit frame, MSB first.
  function automatic logic [1:0] frame_bit(int off, int w, logic [15:0] word);
    int i;
    i = off / (2 * D);
    if (i < w) return {((off % (2 * D)) >= D), word[w-1-i]};
    return {1'b0, word[0]};
  endfunction

  function automatic logic [11:0] model_pins(bit run, int pos, bit dn);
    logic a4, a3, b3, b2;
    logic [1:0] ca, cb, cs;
    logic [15:0] spi_w;
    spi_w = {1'b0, SPI_WORD[14:0]};
    a4 = 1'b1; a3 = 1'b1; b3 = 1'b1; b2 = 1'b0;
    ca = 2'b00; cb = 2'b00; cs = 2'b00;
    if (run) begin
      if (pos < LA) begin
        a3 = 1'b0;
        ca = frame_bit(pos, 8, {8'h00, GAIN_A});
      end else if (pos >= LA + G && pos < LA + G + LB) begin
        b3 = 1'b0;
        cb = frame_bit(pos - LA - G, 8, {8'h00, GAIN_B});
      end else if (pos >= SPI_START) begin
        a4 = 1'b0;
        cs = frame_bit(pos - SPI_START, 16, spi_w);
      end
    end else if (dn && GS_ON) begin
      b3 = GS_CODE[1];
      b2 = GS_CODE[0];
    end
    return {a4, dn & ~run, a3, 1'b0, ca, cs[1], b3, b2, cb, cs[0]};
  endfunction

  task automatic check_output(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%b want=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_value(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one position counter along the sequence timeline.
  bit m_valid = 1'b0;
  bit m_run   = 1'b0;
  bit m_done  = 1'b0;
  bit m_prev  = 1'b0;
  int m_pos   = 0;

  always @(posedge main_clk) begin
    if (!rst_n) begin
      m_valid = 1'b1;
      m_run   = 1'b0;
      m_done  = 1'b0;
      m_prev  = 1'b0;
      m_pos   = 0;
    end else begin
      if (m_run) begin
        m_pos++;
        if (m_pos == TOTAL) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end else if (start && !m_prev) begin
        m_run  = 1'b1;
        m_done = 1'b0;
        m_pos  = 0;
      end
      m_prev = start;
    end
  end

  int   mon_cnt[3];
  int   mon_sh[3];
  logic mon_prev_cs[3];
  logic mon_prev_clk[3];
  logic mon_prev_a5;
  int   a5_rises = 0;

  task automatic track_frame(input int k, input logic cs, input logic clk, input logic dat,
                             input int len, input int word, input string name);
    if (!cs) begin
      mon_cnt[k]++;
      if (clk && !mon_prev_clk[k]) mon_sh[k] = ((mon_sh[k] << 1) | int'(dat)) & 32'hFFFF;
    end else if (!mon_prev_cs[k]) begin
      check_value({name, "_cs_low_cycles"}, mon_cnt[k], len);
      check_value({name, "_word"}, mon_sh[k], word);
      mon_cnt[k] = 0;
      mon_sh[k]  = 0;
    end
    mon_prev_cs[k]  = cs;
    mon_prev_clk[k] = clk;
  endtask

  // Per-cycle model comparison plus literal frame checks, sampled on the falling edge.
  always @(negedge main_clk) begin
    if (m_valid) check_output("pins", dut_pins, model_pins(m_run, m_pos, m_done));
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mon_cnt[k]      = 0;
        mon_sh[k]       = 0;
        mon_prev_cs[k]  = 1'b1;
        mon_prev_clk[k] = 1'b0;
      end
      mon_prev_a5 = 1'b0;
    end else begin
      if (A4 && !mon_prev_cs[2]) check_value("a5_when_a4_rises", int'(A5), 1);
      if (A5 && !mon_prev_a5) a5_rises++;
      mon_prev_a5 = A5;
      track_frame(0, A3_csa, A1_clka, A0_data, 68, 32'h00A5, "frame_a");
      track_frame(1, B3_csb_gs1, B1_clkb, B0_datb, 68, 32'h003C, "frame_b");
      track_frame(2, A4, B4_sclk, B5_spi_sdio, 132, 32'h0A81, "frame_spi");
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge main_clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic s, input int hold);
    start = s;
    step(hold);
  endtask

  // Leaves the bench one cycle after the start edge has been accepted.
  task automatic launch();
    apply_stimulus(1'b0, 2);
    apply_stimulus(1'b1, 1);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rises_before;
    int r;

    step(1);
    for (int i = 0; i < 3; i++) apply_stimulus(i[0] ? 1'b0 : 1'b1, 1);
    check_output("reset_state", dut_pins, PINS_IDLE);
    start = 1'b0;
    rst_n = 1'b1;
    step(3);
    check_output("idle_after_reset", dut_pins, PINS_IDLE);

    $display("[TB] basic sequence");
    rises_before = a5_rises;
    launch();
    step(TOTAL + 4);
    check_output("done_state", dut_pins, PINS_DONE);
    check_value("a5_rises_basic", a5_rises - rises_before, 1);

    $display("[TB] restart from DONE with busy start pulses");
    rises_before = a5_rises;
    launch();
    step(LA + G + 10);
    apply_stimulus(1'b0, 3);
    apply_stimulus(1'b1, 3);
    apply_stimulus(1'b0, 3);
    apply_stimulus(1'b1, 3);
    step(TOTAL);
    check_output("done_after_busy", dut_pins, PINS_DONE);
    check_value("a5_rises_busy", a5_rises - rises_before, 1);

    $display("[TB] reset in the middle of the SPI frame");
    launch();
    step(189);
    check_output("spi_mid_frame", dut_pins, 12'b0010_0011_0001);
    rst_n = 1'b0;
    step(1);
    check_output("abort_state", dut_pins, PINS_IDLE);
    step(1);
    rst_n = 1'b1;
    rises_before = a5_rises;
    launch();
    step(TOTAL + 2);
    check_output("done_after_abort", dut_pins, PINS_DONE);
    check_value("a5_rises_after_abort", a5_rises - rises_before, 1);

    $display("[TB] randomized start and reset activity");
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        rst_n = 1'b0;
        step(int'($urandom_range(1, 3)));
        rst_n = 1'b1;
      end else begin
        apply_stimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 60)));
      end
    end
    apply_stimulus(1'b0, TOTAL + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
